// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: address map defaults, FSM state and grant encodings.
package mem_pkg;

  localparam logic [63:0] BASE_ADDR_DEF = 64'h0000_0000_8000_0000;
  localparam logic [63:0] MEM_BYTES_DEF = 64'h0000_0000_0800_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RSP_IF = 2'd1,
    RSP_DM = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter_addr_check.sv
// Converts a byte address into a BASE-relative 64-bit word index and flags
// out-of-range or misaligned accesses.
module mem_addr_check #(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MEM_BYTES  = 64'h0000_0000_0800_0000,
  parameter int          ALIGN_BITS = 3
) (
  input  logic [63:0] addr,
  output logic [63:0] idx,
  output logic        err
);

  localparam logic [63:0] LIMIT      = BASE_ADDR + MEM_BYTES;
  localparam logic [63:0] ALIGN_MASK = (64'd1 << ALIGN_BITS) - 64'd1;

  logic [63:0] offset;
  logic        misalign;
  logic        out_of_range;

  // Addresses below BASE wrap to huge offsets; the range check rejects them.
  assign offset       = addr - BASE_ADDR;
  assign idx          = offset >> 3;
  assign misalign     = (addr & ALIGN_MASK) != 64'd0;
  assign out_of_range = (addr < BASE_ADDR) || (addr >= LIMIT);
  assign err          = misalign || out_of_range;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of the single RAMHelper port between the fetch and data requesters,
// with a registered one-cycle response per accepted request.
//   state  | meaning
//   IDLE   | no response pending
//   RSP_IF | fetch response valid this cycle
//   RSP_DM | data response valid this cycle
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter logic [63:0] MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_inst,
  output logic        if_rsp_err,
  input  logic        dm_req_valid,
  output logic        dm_req_ready,
  input  logic        dm_req_wen,
  input  logic [63:0] dm_req_addr,
  input  logic [63:0] dm_req_wdata,
  input  logic [63:0] dm_req_wmask,
  output logic        dm_rsp_valid,
  output logic [63:0] dm_rsp_rdata,
  output logic        dm_rsp_err,
  output logic        ram_en,
  output logic [63:0] ram_rIdx,
  input  logic [63:0] ram_rdata,
  output logic [63:0] ram_wIdx,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask,
  output logic        ram_wen
);

  state_t      state;
  grant_t      last_grant;
  logic [63:0] if_idx;
  logic [63:0] dm_idx;
  logic        if_err;
  logic        dm_err;
  logic        gnt_if;
  logic        gnt_dm;
  logic [31:0] inst_sel;

  mem_addr_check #(
    .BASE_ADDR  (BASE_ADDR),
    .MEM_BYTES  (MEM_BYTES),
    .ALIGN_BITS (2)
  ) u_if_check (
    .addr (if_req_addr),
    .idx  (if_idx),
    .err  (if_err)
  );

  mem_addr_check #(
    .BASE_ADDR  (BASE_ADDR),
    .MEM_BYTES  (MEM_BYTES),
    .ALIGN_BITS (3)
  ) u_dm_check (
    .addr (dm_req_addr),
    .idx  (dm_idx),
    .err  (dm_err)
  );

  // DM wins a tie unless it was the last one granted.
  assign gnt_dm = rst_n && dm_req_valid && (!if_req_valid || (last_grant == GNT_IF));
  assign gnt_if = rst_n && if_req_valid && !gnt_dm;

  assign if_req_ready = gnt_if;
  assign dm_req_ready = gnt_dm;

  assign ram_en    = (gnt_if && !if_err) || (gnt_dm && !dm_err && !dm_req_wen);
  assign ram_rIdx  = gnt_dm ? dm_idx : if_idx;
  assign ram_wen   = gnt_dm && !dm_err && dm_req_wen;
  assign ram_wIdx  = dm_idx;
  assign ram_wdata = dm_req_wdata;
  assign ram_wmask = dm_req_wmask;

  assign inst_sel = if_req_addr[2] ? ram_rdata[63:32] : ram_rdata[31:0];

  assign if_rsp_valid = (state == RSP_IF);
  assign dm_rsp_valid = (state == RSP_DM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= GNT_IF;
      if_rsp_inst  <= '0;
      if_rsp_err   <= 1'b0;
      dm_rsp_rdata <= '0;
      dm_rsp_err   <= 1'b0;
    end else begin
      if_rsp_inst  <= '0;
      if_rsp_err   <= 1'b0;
      dm_rsp_rdata <= '0;
      dm_rsp_err   <= 1'b0;
      if (gnt_if) begin
        state      <= RSP_IF;
        last_grant <= GNT_IF;
        if_rsp_err <= if_err;
        if (!if_err) if_rsp_inst <= inst_sel;
      end else if (gnt_dm) begin
        state      <= RSP_DM;
        last_grant <= GNT_DM;
        dm_rsp_err <= dm_err;
        if (!dm_err && !dm_req_wen) dm_rsp_rdata <= ram_rdata;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural RAMHelper model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
  logic [63:0] if_req_addr;
  logic [31:0] if_rsp_inst;
  logic        dm_req_valid, dm_req_ready, dm_req_wen, dm_rsp_valid, dm_rsp_err;
  logic [63:0] dm_req_addr, dm_req_wdata, dm_req_wmask, dm_rsp_rdata;
  logic        ram_en, ram_wen;
  logic [63:0] ram_rIdx, ram_rdata, ram_wIdx, ram_wdata, ram_wmask;

  logic [63:0] mem [16];
  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_inst(if_rsp_inst), .if_rsp_err(if_rsp_err),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_wen(dm_req_wen),
    .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata), .dm_req_wmask(dm_req_wmask),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata), .dm_rsp_err(dm_rsp_err),
    .ram_en(ram_en), .ram_rIdx(ram_rIdx), .ram_rdata(ram_rdata), .ram_wIdx(ram_wIdx),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_wen(ram_wen)
  );

  assign ram_rdata = mem[ram_rIdx[3:0]];

  always @(posedge clk)
    if (ram_wen)
      mem[ram_wIdx[3:0]] <= (mem[ram_wIdx[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change at posedge+1; combinational checks at posedge+4; responses at posedge+1.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_valid = 1'b0; if_req_addr = '0;
    dm_req_valid = 1'b0; dm_req_wen = 1'b0; dm_req_addr = '0;
    dm_req_wdata = '0; dm_req_wmask = '0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 64'd0;
    mem[0] = 64'hAAAA_BBBB_CCCC_DDDD;
    mem[1] = 64'h1111_2222_3333_4444;

    // Reset with both requesters pushing, including a write
    rst_n = 1'b0;
    idle_inputs();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
    dm_req_valid = 1'b1; dm_req_wen = 1'b1; dm_req_addr = 64'h8000_0018;
    dm_req_wdata = '1; dm_req_wmask = '1;
    for (int c = 0; c < 3; c++) begin
      #4;
      chk("rst_if_ready", {63'd0, if_req_ready}, 64'd0);
      chk("rst_dm_ready", {63'd0, dm_req_ready}, 64'd0);
      chk("rst_ram_wen",  {63'd0, ram_wen}, 64'd0);
      chk("rst_ram_en",   {63'd0, ram_en}, 64'd0);
      chk("rst_rsp_valid", {62'd0, if_rsp_valid, dm_rsp_valid}, 64'd0);
      next_cycle();
    end
    chk("rst_mem_untouched", mem[3], 64'd0);
    idle_inputs();
    rst_n = 1'b1;
    next_cycle();

    // Fetch upper then lower half of word 0, back to back
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0004;
    #3;
    chk("f1_ready", {63'd0, if_req_ready}, 64'd1);
    chk("f1_ram_en", {63'd0, ram_en}, 64'd1);
    chk("f1_ridx", ram_rIdx, 64'd0);
    next_cycle();
    chk("f1_valid", {63'd0, if_rsp_valid}, 64'd1);
    chk("f1_inst", {32'd0, if_rsp_inst}, 64'hAAAA_BBBB);
    chk("f1_err", {63'd0, if_rsp_err}, 64'd0);
    if_req_addr = 64'h8000_0000;
    next_cycle();
    chk("f2_valid", {63'd0, if_rsp_valid}, 64'd1);
    chk("f2_inst", {32'd0, if_rsp_inst}, 64'hCCCC_DDDD);
    idle_inputs();
    #3;
    chk("idle_ram_en", {63'd0, ram_en}, 64'd0);
    next_cycle();
    chk("idle_rsp", {62'd0, if_rsp_valid, dm_rsp_valid}, 64'd0);

    // Contention: alternating grants, DM first since IF was last granted
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0008;
    dm_req_valid = 1'b1; dm_req_addr = 64'h8000_0000;
    for (int k = 0; k < 4; k++) begin
      #3;
      chk("rr_dm_ready", {63'd0, dm_req_ready}, (k % 2 == 0) ? 64'd1 : 64'd0);
      chk("rr_if_ready", {63'd0, if_req_ready}, (k % 2 == 0) ? 64'd0 : 64'd1);
      next_cycle();
      chk("rr_rsp", {62'd0, if_rsp_valid, dm_rsp_valid}, (k % 2 == 0) ? 64'd1 : 64'd2);
      if (k % 2 == 0) chk("rr_dm_data", dm_rsp_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
      else            chk("rr_if_data", {32'd0, if_rsp_inst}, 64'h3333_4444);
    end
    idle_inputs();

    // Masked write then immediate read of the same word
    dm_req_valid = 1'b1; dm_req_wen = 1'b1; dm_req_addr = 64'h8000_0010;
    dm_req_wdata = 64'h1122_3344_5566_7788; dm_req_wmask = 64'h0000_0000_FFFF_FFFF;
    #3;
    chk("wr_wen", {63'd0, ram_wen}, 64'd1);
    chk("wr_widx", ram_wIdx, 64'd2);
    chk("wr_ram_en", {63'd0, ram_en}, 64'd0);
    next_cycle();
    chk("wr_rsp_valid", {63'd0, dm_rsp_valid}, 64'd1);
    chk("wr_rsp_rdata", dm_rsp_rdata, 64'd0);
    dm_req_wen = 1'b0;
    next_cycle();
    chk("rd_after_wr", dm_rsp_rdata, 64'h0000_0000_5566_7788);
    chk("rd_after_wr_err", {63'd0, dm_rsp_err}, 64'd0);
    idle_inputs();

    // Out-of-range and misaligned data reads
    begin
      logic [63:0] bad [3];
      bad[0] = 64'h7FFF_FFF8; bad[1] = 64'h8800_0000; bad[2] = 64'h8000_0003;
      for (int b = 0; b < 3; b++) begin
        dm_req_valid = 1'b1; dm_req_addr = bad[b];
        #3;
        chk("err_ready", {63'd0, dm_req_ready}, 64'd1);
        chk("err_ram_en", {63'd0, ram_en}, 64'd0);
        next_cycle();
        chk("err_valid", {63'd0, dm_rsp_valid}, 64'd1);
        chk("err_flag", {63'd0, dm_rsp_err}, 64'd1);
        chk("err_rdata", dm_rsp_rdata, 64'd0);
      end
    end
    idle_inputs();

    // Misaligned fetch
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0002;
    #3;
    chk("ferr_ram_en", {63'd0, ram_en}, 64'd0);
    next_cycle();
    chk("ferr_flag", {63'd0, if_rsp_err}, 64'd1);
    chk("ferr_inst", {32'd0, if_rsp_inst}, 64'd0);
    idle_inputs();

    // Reset hitting a pending DM response; afterwards DM wins the first tie
    dm_req_valid = 1'b1; dm_req_addr = 64'h8000_0008;
    next_cycle();
    idle_inputs();
    chk("pre_rst_valid", {63'd0, dm_rsp_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, dm_rsp_valid}, 64'd0);
    chk("mid_rst_rdata", dm_rsp_rdata, 64'd0);
    next_cycle();
    rst_n = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
    dm_req_valid = 1'b1; dm_req_addr = 64'h8000_0000;
    #3;
    chk("post_rst_dm_first", {62'd0, if_req_ready, dm_req_ready}, 64'd1);
    next_cycle();
    idle_inputs();
    chk("post_rst_dm_rsp", {62'd0, if_rsp_valid, dm_rsp_valid}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
